debug_initiator: RTL and testbench
==================================

Name: debug_initiator

Overview:
Single-master initiator for the per-core debug bus (sel/addr/we/wdata/rdata) that feeds the debug mux. It takes one command at a time from a host-side valid/ready channel and runs a fixed-timing bus access. It returns the sampled read data on a valid/ready response channel. An optional poll mode repeats a read until the value is nonzero or a retry limit expires, for example to wait for a core's stopped flag.

Parameters:
CORES, 4, number of cores behind the mux
LOG_CORES, 2, width of core select
DATA_WIDTH, 8, debug data width
MAX_POLLS, 16, max read accesses per poll command (>=1)
POLL_CNT_W, 4, counter width; must hold 0..MAX_POLLS-1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  block can accept a command
cmd_sel  in  LOG_CORES  target core
cmd_addr  in  5  debug address
cmd_we  in  1  1=write, 0=read
cmd_wdata  in  DATA_WIDTH  write data
cmd_poll  in  1  poll mode (only honoured when cmd_we=0)
rsp_valid  out  1  response valid
rsp_ready  in  1  host takes response
rsp_data  out  DATA_WIDTH  rdata sampled on the final access
rsp_timeout  out  1  poll ended without a nonzero read
sel  out  LOG_CORES  debug bus core select
addr  out  5  debug bus address
we  out  1  debug bus write strobe
wdata  out  DATA_WIDTH  debug bus write data
rdata  in  DATA_WIDTH  debug bus read data (combinational from mux)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0 except cmd_ready=1.
  - Poll counter 0.
- FSM states are IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the command and go to SETUP.
  - sel, addr and wdata take the command values at this edge.
- SETUP (1 cycle):
  - sel, addr and wdata are stable; we=0. This guarantees address setup before the strobe.
  - Go to ACCESS.
- ACCESS (1 cycle):
  - we=1 only if the latched command is a write.
  - rdata is sampled into rsp_data at the closing edge. For writes this is the pre-write value.
  - Write or non-poll read: go to RESP.
  - Poll read, sampled rdata!=0: go to RESP, rsp_timeout=0.
  - Poll read, rdata==0 and counter<MAX_POLLS-1: increment the counter and stay in ACCESS. we stays 0 and the bus is held.
  - Poll read, rdata==0 and counter==MAX_POLLS-1: go to RESP, rsp_timeout=1, rsp_data=0.
- RESP:
  - rsp_valid=1. rsp_data and rsp_timeout are held stable until rsp_ready.
  - On rsp_ready, go to IDLE: rsp_valid=0, counter cleared, rsp_timeout cleared.
- cmd_ready=0 in every state except IDLE. There is no pipelining, so a new command is never accepted in the cycle of the response handshake.
- Latency, with accept edge = 0:
  - SETUP in cycle 1, ACCESS in cycle 2, rsp_valid from cycle 3.
  - Minimum command-to-command period is 4 cycles.
  - A poll that succeeds on access k (1-based) has rsp_valid from cycle 2+k.
- Outside SETUP/ACCESS: we=0 always, and sel/addr/wdata hold their last values, so there is no toggling on the idle bus.
- we is high for exactly one cycle per write command and never high for reads.
- cmd_poll with cmd_we=1 is ignored; the command behaves as a plain write.
- MAX_POLLS=1: a poll behaves as a single read, with timeout=1 if the value read is 0.
- Reset asserted mid-operation: we drops immediately (async). Any pending response is discarded and the block returns to IDLE.
- Command inputs are ignored while cmd_ready=0.

Test Plan:
- Write: cmd sel=1 addr=01100 we=1 wdata=AA, rdata=E1 -> bus sel=1 addr=01100 wdata=AA; we=1 only in cycle 2; rsp_valid cycle 3 with rsp_data=E1, timeout=0.
- Read: cmd sel=2 addr=10000 we=0, rdata=C3 -> we never asserted; rsp_data=C3 at cycle 3; next command accepted the cycle after rsp handshake.
- Poll success: cmd poll=1 we=0, rdata=00 for 3 ACCESS cycles then 01 -> 4 ACCESS cycles, rsp_valid cycle 6, rsp_data=01, timeout=0.
- Poll timeout: MAX_POLLS=16, rdata stuck 00 -> exactly 16 ACCESS cycles, then rsp_data=00, rsp_timeout=1; counter 0 on return to IDLE.
- Backpressure: rsp_ready held low 5 cycles with cmd_valid high -> rsp_valid/rsp_data stable, cmd_ready=0, we=0 throughout; IDLE one cycle after rsp_ready.
- Async reset during ACCESS of a write -> we falls without a clock edge; rsp_valid=0, cmd_ready=1 after release; no response emitted.

Source files
------------

// File: rtl/debug_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module   : debug_initiator_if
//  Brief    : Host command/response channels and per-core debug bus bundle
//             for the debug initiator.
//  Revision : 1.0 - initial release
// ============================================================================
interface debug_initiator_if #(
    parameter int LOG_CORES  = 2,
    parameter int DATA_WIDTH = 8
);
    // host command channel
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LOG_CORES-1:0]  cmd_sel;
    logic [4:0]            cmd_addr;
    logic                  cmd_we;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  cmd_poll;

    // host response channel
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_timeout;

    // debug bus towards the mux
    logic [LOG_CORES-1:0]  sel;
    logic [4:0]            addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    // initiator side: accepts commands, returns responses, drives the bus
    modport master (
        input  cmd_valid, cmd_sel, cmd_addr, cmd_we, cmd_wdata, cmd_poll,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_timeout,
        input  rsp_ready,
        output sel, addr, we, wdata,
        input  rdata
    );

    // host and debug-mux side
    modport slave (
        output cmd_valid, cmd_sel, cmd_addr, cmd_we, cmd_wdata, cmd_poll,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_timeout,
        output rsp_ready,
        input  sel, addr, we, wdata,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/debug_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : debug_initiator
//  Brief    : Single-outstanding initiator for the per-core debug bus.
//             Runs a fixed SETUP/ACCESS bus cycle per command, with an
//             optional poll mode that repeats a read until nonzero or until
//             the retry limit expires.
//  Revision : 1.0 - initial release
// ============================================================================
module debug_initiator #(
    parameter int CORES      = 4,
    parameter int LOG_CORES  = 2,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_POLLS  = 16,
    parameter int POLL_CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    debug_initiator_if.master bus
);

    // Counter value of the final permitted poll access
    localparam logic [POLL_CNT_W-1:0] C_LAST_POLL = POLL_CNT_W'(MAX_POLLS - 1);

    // Reject parameter sets the select or counter widths cannot represent
    generate
        if (MAX_POLLS < 1 || MAX_POLLS > (1 << POLL_CNT_W) ||
            CORES < 1 || CORES > (1 << LOG_CORES)) begin : g_bad_params
            $error("debug_initiator: inconsistent parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                r_state,       w_state;
    logic [POLL_CNT_W-1:0] r_cnt,         w_cnt;
    logic                  r_is_write,    w_is_write;
    logic                  r_is_poll,     w_is_poll;
    logic                  r_cmd_ready,   w_cmd_ready;
    logic                  r_rsp_valid,   w_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data,    w_rsp_data;
    logic                  r_rsp_timeout, w_rsp_timeout;
    logic [LOG_CORES-1:0]  r_sel,         w_sel;
    logic [4:0]            r_addr,        w_addr;
    logic                  r_we,          w_we;
    logic [DATA_WIDTH-1:0] r_wdata,       w_wdata;

    logic                  w_rdata_zero;

    assign w_rdata_zero = (bus.rdata == '0);

    // State and registered-output flops; reset clears the bus strobe at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_is_write    <= 1'b0;
            r_is_poll     <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_sel         <= '0;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_is_write    <= w_is_write;
            r_is_poll     <= w_is_poll;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_data    <= w_rsp_data;
            r_rsp_timeout <= w_rsp_timeout;
            r_sel         <= w_sel;
            r_addr        <= w_addr;
            r_we          <= w_we;
            r_wdata       <= w_wdata;
        end
    end

    // Next-state and next-output logic; the bus holds its last values unless
    // a new command is latched, and the strobe defaults low every cycle
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_is_write    = r_is_write;
        w_is_poll     = r_is_poll;
        w_cmd_ready   = r_cmd_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_data    = r_rsp_data;
        w_rsp_timeout = r_rsp_timeout;
        w_sel         = r_sel;
        w_addr        = r_addr;
        w_we          = 1'b0;
        w_wdata       = r_wdata;

        case (r_state)
            IDLE: begin
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state     = SETUP;
                    w_cmd_ready = 1'b0;
                    w_cnt       = '0;
                    w_sel       = bus.cmd_sel;
                    w_addr      = bus.cmd_addr;
                    w_wdata     = bus.cmd_wdata;
                    w_is_write  = bus.cmd_we;
                    // a poll request on a write is meaningless; treat as write
                    w_is_poll   = bus.cmd_poll && !bus.cmd_we;
                end
            end

            SETUP: begin
                // address has had a full cycle to settle before the strobe
                w_state = ACCESS;
                w_we    = r_is_write;
            end

            ACCESS: begin
                if (r_is_poll && w_rdata_zero && (r_cnt != C_LAST_POLL)) begin
                    // retry the same read with the bus held and no strobe
                    w_cnt = r_cnt + 1'b1;
                end else begin
                    w_state       = RESP;
                    w_rsp_valid   = 1'b1;
                    // on a write this captures the value before the write lands
                    w_rsp_data    = bus.rdata;
                    w_rsp_timeout = r_is_poll && w_rdata_zero;
                end
            end

            RESP: begin
                if (bus.rsp_ready) begin
                    w_state       = IDLE;
                    w_rsp_valid   = 1'b0;
                    w_rsp_timeout = 1'b0;
                    w_cnt         = '0;
                    w_cmd_ready   = 1'b1;
                end
            end

            default: begin
                w_state     = IDLE;
                w_cmd_ready = 1'b1;
                w_rsp_valid = 1'b0;
                w_cnt       = '0;
            end
        endcase
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.sel         = r_sel;
    assign bus.addr        = r_addr;
    assign bus.we          = r_we;
    assign bus.wdata       = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_debug_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_debug_initiator
//  Brief    : Self-checking bench for debug_initiator: directed and random
//             commands compared against a per-command behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_debug_initiator;

    localparam int LOGC = 2;
    localparam int DW   = 8;
    localparam int MAXP = 16;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    debug_initiator_if #(.LOG_CORES(LOGC), .DATA_WIDTH(DW)) bus ();

    debug_initiator #(
        .CORES      (4),
        .LOG_CORES  (LOGC),
        .DATA_WIDTH (DW),
        .MAX_POLLS  (MAXP),
        .POLL_CNT_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge while the DUT is idle. Builds the read-data
    // sequence the mux will return on successive accesses, predicts the
    // outcome from the command rules, then drives and checks every cycle.
    task automatic run_cmd(input logic [LOGC-1:0] s, input logic [4:0] a,
                           input logic w, input logic [DW-1:0] wd,
                           input logic p, input int zeros,
                           input logic [DW-1:0] val, input int dly);
        logic [DW-1:0] seq [0:MAXP];
        int            n;
        logic [DW-1:0] exp_data;
        logic          exp_to;

        for (int i = 0; i <= MAXP; i++)
            seq[i] = (i < zeros) ? 8'h00 : ((i == zeros) ? val : DW'($urandom));

        // model: writes and plain reads take one access; polls stop on the
        // first nonzero value or give up after MAXP zero reads
        if (w || !p) begin
            n = 1; exp_data = seq[0]; exp_to = 1'b0;
        end else begin
            n = MAXP; exp_data = '0; exp_to = 1'b1;
            for (int k = MAXP - 1; k >= 0; k--)
                if (seq[k] != '0) begin
                    n = k + 1; exp_data = seq[k]; exp_to = 1'b0;
                end
        end

        bus.cmd_valid = 1'b1; bus.cmd_sel = s; bus.cmd_addr = a;
        bus.cmd_we = w; bus.cmd_wdata = wd; bus.cmd_poll = p;
        chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk); #1;

        // cycles 1 .. 1+n: SETUP then n ACCESS cycles
        for (int c = 1; c < 2 + n; c++) begin
            bus.cmd_valid = 1'(($urandom));
            bus.cmd_sel = LOGC'($urandom); bus.cmd_addr = 5'($urandom);
            bus.cmd_we = 1'($urandom); bus.cmd_wdata = DW'($urandom);
            bus.cmd_poll = 1'($urandom);
            bus.rdata = (c >= 2) ? seq[c-2] : DW'($urandom);
            @(negedge clk);
            chk("busy_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            chk("busy_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("busy_we",        32'(bus.we),        32'(w && c == 2));
            chk("busy_sel",       32'(bus.sel),       32'(s));
            chk("busy_addr",      32'(bus.addr),      32'(a));
            chk("busy_wdata",     32'(bus.wdata),     32'(wd));
            @(posedge clk); #1;
        end

        // response cycles, ready withheld for dly cycles
        for (int c = 0; c <= dly; c++) begin
            bus.rsp_ready = (c == dly);
            bus.cmd_valid = 1'b1;
            bus.cmd_sel = LOGC'($urandom); bus.cmd_addr = 5'($urandom);
            bus.cmd_we = 1'($urandom); bus.cmd_wdata = DW'($urandom);
            bus.rdata = DW'($urandom);
            @(negedge clk);
            chk("rsp_valid",      32'(bus.rsp_valid),   32'd1);
            chk("rsp_data",       32'(bus.rsp_data),    32'(exp_data));
            chk("rsp_timeout",    32'(bus.rsp_timeout), 32'(exp_to));
            chk("rsp_cmd_ready",  32'(bus.cmd_ready),   32'd0);
            chk("rsp_we",         32'(bus.we),          32'd0);
            chk("rsp_sel_hold",   32'(bus.sel),         32'(s));
            @(posedge clk); #1;
        end

        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        chk("post_cmd_ready",   32'(bus.cmd_ready),   32'd1);
        chk("post_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("post_we",          32'(bus.we),          32'd0);
        chk("post_addr_hold",   32'(bus.addr),        32'(a));
        chk("post_wdata_hold",  32'(bus.wdata),       32'(wd));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_addr = '0;
        bus.cmd_we = 1'b0; bus.cmd_wdata = '0; bus.cmd_poll = 1'b0;
        bus.rsp_ready = 1'b0; bus.rdata = '0;

        // reset state
        #12;
        chk("rst_cmd_ready",   32'(bus.cmd_ready),   32'd1);
        chk("rst_rsp_valid",   32'(bus.rsp_valid),   32'd0);
        chk("rst_rsp_data",    32'(bus.rsp_data),    32'd0);
        chk("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        chk("rst_we",          32'(bus.we),          32'd0);
        chk("rst_sel",         32'(bus.sel),         32'd0);
        chk("rst_addr",        32'(bus.addr),        32'd0);
        chk("rst_wdata",       32'(bus.wdata),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // write: sampled rdata is the pre-write value
        run_cmd(2'd1, 5'b01100, 1'b1, 8'hAA, 1'b0, 0, 8'hE1, 0);
        // plain read, back-to-back with the previous command
        run_cmd(2'd2, 5'b10000, 1'b0, 8'h00, 1'b0, 0, 8'hC3, 0);
        // poll success on the 4th access
        run_cmd(2'd0, 5'b00011, 1'b0, 8'h00, 1'b1, 3, 8'h01, 0);
        // poll timeout after exactly MAXP accesses
        run_cmd(2'd3, 5'b00111, 1'b0, 8'h00, 1'b1, MAXP, 8'h5A, 0);
        // poll success on the very last permitted access
        run_cmd(2'd3, 5'b00111, 1'b0, 8'h00, 1'b1, MAXP - 1, 8'h80, 0);
        // response backpressure for 5 cycles
        run_cmd(2'd1, 5'b11111, 1'b0, 8'h00, 1'b0, 0, 8'h77, 5);
        // poll flag on a write is ignored: single access, zero data accepted
        run_cmd(2'd2, 5'b00001, 1'b1, 8'h3C, 1'b1, 2, 8'h10, 1);

        // randomized commands
        for (int i = 0; i < 25; i++)
            run_cmd(LOGC'($urandom), 5'($urandom), 1'($urandom), DW'($urandom),
                    1'($urandom), int'($urandom_range(0, MAXP + 1)),
                    DW'($urandom_range(1, 255)), int'($urandom_range(0, 3)));

        // async reset while a write strobe is on the bus
        bus.cmd_valid = 1'b1; bus.cmd_sel = 2'd1; bus.cmd_addr = 5'b00110;
        bus.cmd_we = 1'b1; bus.cmd_wdata = 8'h99; bus.cmd_poll = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_we", 32'(bus.we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we",        32'(bus.we),        32'd0);
        chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("async_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
            chk("post_rst_we",        32'(bus.we),        32'd0);
        end
        bus.rsp_ready = 1'b0;
        // block recovers normally; a poll relies on a cleared counter
        run_cmd(2'd0, 5'b01010, 1'b0, 8'h00, 1'b1, MAXP, 8'h11, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
